// File: rtl/ahb3lite_interconnect_master_port.sv
// ahb3lite_interconnect_master_port
//
// Per-master front end of an AHB3-Lite multi-layer switch. Decodes the master's
// address phase onto one of SLAVES request lines, holds the address phase while
// the target slave port has not granted this master, routes the data-phase
// response back from the selected slave port, tracks fixed-length bursts so the
// slave-port arbiters know when switching away is safe, and answers unmapped
// accesses with a two-cycle ERROR response.
//
// Ports:
//   HCLK, HRESET                  clock, synchronous active-high reset
//   slvHADDRbase/slvHADDRmask     per-slave address decode window
//   HSEL..HREADY                  master-side address/data phase inputs
//   HRDATA, HREADYOUT, HRESP      response to the master
//   slvHSEL                       per-slave request / select
//   slvHADDR..slvHREADY           address phase shared by all slave ports
//   slvHRDATA/HREADYOUT/HRESP     per-slave-port response
//   can_switch                    arbiter of slave s may switch away from us
//   granted                       slave port s currently grants this master

module ahb3lite_interconnect_master_port #(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32,
    parameter int unsigned SLAVES     = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [HADDR_SIZE-1:0] slvHADDRbase [SLAVES],
    input  logic [HADDR_SIZE-1:0] slvHADDRmask [SLAVES],
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [SLAVES-1:0]     slvHSEL,
    output logic [HADDR_SIZE-1:0] slvHADDR,
    output logic [HDATA_SIZE-1:0] slvHWDATA,
    output logic                  slvHWRITE,
    output logic [2:0]            slvHSIZE,
    output logic [2:0]            slvHBURST,
    output logic [3:0]            slvHPROT,
    output logic [1:0]            slvHTRANS,
    output logic                  slvHMASTLOCK,
    output logic                  slvHREADY,
    input  logic [HDATA_SIZE-1:0] slvHRDATA [SLAVES],
    input  logic [SLAVES-1:0]     slvHREADYOUT,
    input  logic [SLAVES-1:0]     slvHRESP,
    output logic [SLAVES-1:0]     can_switch,
    input  logic [SLAVES-1:0]     granted
);

    localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StWait = 3'd1;
    localparam logic [2:0] StData = 3'd2;
    localparam logic [2:0] StErr1 = 3'd3;
    localparam logic [2:0] StErr2 = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [SW-1:0]         dslv_q, dslv_d;
    logic [3:0]            burst_cnt_q, burst_cnt_d;

    // Held copy of the last active address phase, replayed while waiting for a grant.
    logic [HADDR_SIZE-1:0] hold_haddr_q;
    logic                  hold_hwrite_q;
    logic [2:0]            hold_hsize_q;
    logic [2:0]            hold_hburst_q;
    logic [3:0]            hold_hprot_q;
    logic [1:0]            hold_htrans_q;
    logic                  hold_hmastlock_q;
    logic [SW-1:0]         hold_slv_q;

    logic                  active;
    logic                  mapped;
    logic [SW-1:0]         dec_slv;
    logic                  req_live;
    logic                  accept;
    logic                  new_xfer;
    logic                  in_wait;

    assign active  = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
    assign in_wait = (state_q == StWait);

    // Address decode; iterate downwards so the lowest matching index wins.
    always_comb begin
        mapped  = 1'b0;
        dec_slv = '0;
        for (int s = int'(SLAVES) - 1; s >= 0; s--) begin
            if (((HADDR ^ slvHADDRbase[s]) & slvHADDRmask[s]) == '0) begin
                mapped  = 1'b1;
                dec_slv = SW'(s);
            end
        end
    end

    // A live request is never raised while the error response is still stalling the master.
    assign req_live = active & mapped & (state_q != StErr1);

    always_comb begin
        slvHSEL = '0;
        if (in_wait) begin
            slvHSEL[hold_slv_q] = 1'b1;
        end else if (req_live) begin
            slvHSEL[dec_slv] = 1'b1;
        end
    end

    assign accept = |(slvHSEL & granted & slvHREADYOUT);

    // Shared address phase: held copy while waiting, live master inputs otherwise.
    assign slvHADDR     = in_wait ? hold_haddr_q     : HADDR;
    assign slvHWRITE    = in_wait ? hold_hwrite_q    : HWRITE;
    assign slvHSIZE     = in_wait ? hold_hsize_q     : HSIZE;
    assign slvHBURST    = in_wait ? hold_hburst_q    : HBURST;
    assign slvHPROT     = in_wait ? hold_hprot_q     : HPROT;
    assign slvHTRANS    = in_wait ? hold_htrans_q    : HTRANS;
    assign slvHMASTLOCK = in_wait ? hold_hmastlock_q : HMASTLOCK;
    assign slvHWDATA    = HWDATA;
    assign slvHREADY    = HREADYOUT;

    assign can_switch = {SLAVES{(burst_cnt_q == 4'd0) & ~slvHMASTLOCK}};

    // Response to the master.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        case (state_q)
            StWait: HREADYOUT = 1'b0;
            StData: begin
                HRDATA    = slvHRDATA[dslv_q];
                HREADYOUT = slvHREADYOUT[dslv_q];
                HRESP     = slvHRESP[dslv_q];
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            StErr2: HRESP = 1'b1;
            default: ;
        endcase
    end

    // Next state. new_xfer marks states that classify a new transfer as from idle.
    always_comb begin
        state_d  = state_q;
        dslv_d   = dslv_q;
        new_xfer = 1'b0;
        case (state_q)
            StIdle, StErr2: new_xfer = 1'b1;
            StWait: begin
                if (accept) begin
                    state_d = StData;
                    dslv_d  = hold_slv_q;
                end
            end
            StData: begin
                if (active) begin
                    new_xfer = 1'b1;
                end else if (slvHREADYOUT[dslv_q]) begin
                    state_d = StIdle;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase

        if (new_xfer) begin
            if (!active) begin
                state_d = StIdle;
            end else if (!mapped) begin
                state_d = StErr1;
            end else if (accept) begin
                state_d = StData;
                dslv_d  = dec_slv;
            end else begin
                state_d = StWait;
            end
        end
    end

    // Beats remaining in the current fixed-length burst.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (HRESP) begin
            burst_cnt_d = 4'd0;
        end
        if (accept) begin
            if (slvHTRANS == HTRANS_NONSEQ) begin
                case (slvHBURST)
                    3'b010, 3'b011: burst_cnt_d = 4'd3;
                    3'b100, 3'b101: burst_cnt_d = 4'd7;
                    3'b110, 3'b111: burst_cnt_d = 4'd15;
                    default:        burst_cnt_d = 4'd0;
                endcase
            end else if (burst_cnt_q != 4'd0) begin
                burst_cnt_d = burst_cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q          <= StIdle;
            dslv_q           <= '0;
            burst_cnt_q      <= '0;
            hold_haddr_q     <= '0;
            hold_hwrite_q    <= 1'b0;
            hold_hsize_q     <= '0;
            hold_hburst_q    <= '0;
            hold_hprot_q     <= '0;
            hold_htrans_q    <= '0;
            hold_hmastlock_q <= 1'b0;
            hold_slv_q       <= '0;
        end else begin
            state_q     <= state_d;
            dslv_q      <= dslv_d;
            burst_cnt_q <= burst_cnt_d;
            if (active && !in_wait) begin
                hold_haddr_q     <= HADDR;
                hold_hwrite_q    <= HWRITE;
                hold_hsize_q     <= HSIZE;
                hold_hburst_q    <= HBURST;
                hold_hprot_q     <= HPROT;
                hold_htrans_q    <= HTRANS;
                hold_hmastlock_q <= HMASTLOCK;
                hold_slv_q       <= dec_slv;
            end
        end
    end

endmodule

// File: tb/tb_ahb3lite_interconnect_master_port.sv
// Self-checking bench for ahb3lite_interconnect_master_port. The master's HREADY
// is looped back from HREADYOUT as on a single-master AHB3-Lite layer.
module tb_ahb3lite_interconnect_master_port;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] base [8];
    logic [31:0] mask [8];
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [7:0]  slvHSEL;
    logic [31:0] slvHADDR;
    logic [31:0] slvHWDATA;
    logic        slvHWRITE;
    logic [2:0]  slvHSIZE;
    logic [2:0]  slvHBURST;
    logic [3:0]  slvHPROT;
    logic [1:0]  slvHTRANS;
    logic        slvHMASTLOCK;
    logic        slvHREADY;
    logic [31:0] srdata [8];
    logic [7:0]  slvHREADYOUT;
    logic [7:0]  slvHRESP;
    logic [7:0]  can_switch;
    logic [7:0]  granted;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;  // beats still to come in the current fixed-length burst

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb3lite_interconnect_master_port #(
        .HADDR_SIZE(32),
        .HDATA_SIZE(32),
        .SLAVES    (8)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .slvHADDRbase(base),
        .slvHADDRmask(mask),
        .HSEL        (HSEL),
        .HADDR       (HADDR),
        .HWDATA      (HWDATA),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HPROT       (HPROT),
        .HTRANS      (HTRANS),
        .HMASTLOCK   (HMASTLOCK),
        .HREADY      (HREADY),
        .HRDATA      (HRDATA),
        .HREADYOUT   (HREADYOUT),
        .HRESP       (HRESP),
        .slvHSEL     (slvHSEL),
        .slvHADDR    (slvHADDR),
        .slvHWDATA   (slvHWDATA),
        .slvHWRITE   (slvHWRITE),
        .slvHSIZE    (slvHSIZE),
        .slvHBURST   (slvHBURST),
        .slvHPROT    (slvHPROT),
        .slvHTRANS   (slvHTRANS),
        .slvHMASTLOCK(slvHMASTLOCK),
        .slvHREADY   (slvHREADY),
        .slvHRDATA   (srdata),
        .slvHREADYOUT(slvHREADYOUT),
        .slvHRESP    (slvHRESP),
        .can_switch  (can_switch),
        .granted     (granted)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Lowest matching window wins; -1 means unmapped.
    function automatic int tb_decode(input logic [31:0] a);
        for (int s = 0; s < 8; s++) begin
            if (((a ^ base[s]) & mask[s]) == 32'h0) return s;
        end
        return -1;
    endfunction

    function automatic int exp_len(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 3;
            3'd4, 3'd5: return 7;
            3'd6, 3'd7: return 15;
            default:    return 0;
        endcase
    endfunction

    task automatic drive_idle();
        HSEL = 1'b0; HTRANS = T_IDLE; HMASTLOCK = 1'b0; HWRITE = 1'b0;
        HBURST = 3'd0; granted = 8'h00; slvHREADYOUT = 8'hFF; slvHRESP = 8'h00;
    endtask

    task automatic test_reset();
        drive_idle();
        HRESET = 1'b1;
        tick();
        tick();
        checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
            failures++;
            $display("FAIL reset_resp got rdy=%b resp=%b rdata=%h exp 1 0 0",
                     HREADYOUT, HRESP, HRDATA);
        end
        checks++;
        if (slvHSEL !== 8'h00 || can_switch !== 8'hFF) begin
            failures++;
            $display("FAIL reset_sel got sel=%h cs=%h exp 00 ff", slvHSEL, can_switch);
        end
        HRESET = 1'b0;
        exp_cnt = 0;
        tick();
    endtask

    // One non-pipelined NONSEQ transfer: gdelay ungranted cycles, swait slave wait states.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] burst,
                        input logic lock, input int gdelay, input int swait, input string tag);
        int          es;
        int          nacc;
        logic [7:0]  onehot;
        logic [31:0] rd;
        logic [31:0] wd;
        es     = tb_decode(addr);
        onehot = (es >= 0) ? (8'h01 << es) : 8'h00;
        nacc   = (es >= 0) ? gdelay : 0;
        HSEL = 1'b1; HADDR = addr; HWRITE = wr; HTRANS = T_NONSEQ; HBURST = burst;
        HMASTLOCK = lock; HSIZE = 3'd2; HPROT = 4'h3; slvHREADYOUT = 8'hFF;
        for (int g = 0; g <= nacc; g++) begin
            granted = (g == gdelay && es >= 0) ? onehot : 8'h00;
            if (g > 0) HADDR = $urandom;
            #1;
            checks++;
            if (slvHSEL !== onehot) begin
                failures++;
                $display("FAIL %s addr_sel c%0d got=%h exp=%h", tag, g, slvHSEL, onehot);
            end
            checks++;
            if (HREADYOUT !== (g == 0) || slvHREADY !== (g == 0) || HRESP !== 1'b0
                || HRDATA !== 32'h0) begin
                failures++;
                $display("FAIL %s addr_resp c%0d got rdy=%b srdy=%b resp=%b rd=%h exp %b",
                         tag, g, HREADYOUT, slvHREADY, HRESP, HRDATA, g == 0);
            end
            checks++;
            if (can_switch !== {8{exp_cnt == 0 && !lock}}) begin
                failures++;
                $display("FAIL %s addr_cs c%0d got=%h exp=%h", tag, g, can_switch,
                         {8{exp_cnt == 0 && !lock}});
            end
            if (es >= 0) begin
                checks++;
                if (slvHADDR !== addr || slvHWRITE !== wr || slvHTRANS !== T_NONSEQ
                    || slvHBURST !== burst || slvHMASTLOCK !== lock || slvHSIZE !== 3'd2
                    || slvHPROT !== 4'h3) begin
                    failures++;
                    $display("FAIL %s addr_phase c%0d got a=%h w=%b t=%b exp a=%h w=%b",
                             tag, g, slvHADDR, slvHWRITE, slvHTRANS, addr, wr);
                end
            end
            tick();
        end
        HTRANS = T_IDLE; HMASTLOCK = 1'b0; granted = 8'h00; HADDR = $urandom;
        if (es >= 0) begin
            exp_cnt = exp_len(burst);
            wd = $urandom; rd = $urandom;
            HWDATA = wd; srdata[es] = rd;
            for (int w = 0; w <= swait; w++) begin
                slvHREADYOUT[es] = (w == swait);
                #1;
                checks++;
                if (HREADYOUT !== (w == swait) || HRDATA !== rd || HRESP !== 1'b0) begin
                    failures++;
                    $display("FAIL %s data w%0d got rdy=%b rd=%h resp=%b exp %b %h 0",
                             tag, w, HREADYOUT, HRDATA, HRESP, w == swait, rd);
                end
                checks++;
                if (slvHSEL !== 8'h00 || can_switch !== {8{exp_cnt == 0}}
                    || (wr && slvHWDATA !== wd)) begin
                    failures++;
                    $display("FAIL %s data_side w%0d got sel=%h cs=%h wd=%h exp 00 %h %h",
                             tag, w, slvHSEL, can_switch, slvHWDATA, {8{exp_cnt == 0}}, wd);
                end
                tick();
            end
            slvHREADYOUT = 8'hFF;
        end else begin
            #1;
            checks++;
            if (HREADYOUT !== 1'b0 || HRESP !== 1'b1 || slvHSEL !== 8'h00) begin
                failures++;
                $display("FAIL %s err1 got rdy=%b resp=%b sel=%h exp 0 1 00",
                         tag, HREADYOUT, HRESP, slvHSEL);
            end
            tick();
            exp_cnt = 0;
            checks++;
            if (HREADYOUT !== 1'b1 || HRESP !== 1'b1 || slvHSEL !== 8'h00
                || can_switch !== 8'hFF) begin
                failures++;
                $display("FAIL %s err2 got rdy=%b resp=%b sel=%h cs=%h exp 1 1 00 ff",
                         tag, HREADYOUT, HRESP, slvHSEL, can_switch);
            end
            tick();
        end
    endtask

    task automatic test_single_write();
        xfer(32'h2000_0010, 1'b1, 3'd0, 1'b0, 0, 0, "single_write");
        xfer(32'h2000_0020, 1'b0, 3'd0, 1'b0, 0, 2, "single_read_wait");
    endtask

    task automatic test_stall();
        xfer(32'h2000_0010, 1'b1, 3'd0, 1'b0, 3, 0, "stall");
    endtask

    task automatic test_unmapped();
        xfer(32'hF000_0000, 1'b0, 3'd0, 1'b0, 0, 0, "unmapped");
    endtask

    task automatic test_lock();
        xfer(32'h1000_0100, 1'b1, 3'd0, 1'b1, 0, 0, "lock");
        xfer(32'h5000_0000, 1'b0, 3'd0, 1'b1, 2, 1, "lock_stall");
    endtask

    // Pipelined bursts to slave 3, always granted and ready.
    task automatic test_back_to_back();
        logic [1:0]  tr [14];
        logic [2:0]  bu [14];
        logic [31:0] rd;
        logic        was_active;
        was_active = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tr[i] = T_SEQ;
            bu[i] = 3'd5;
        end
        tr[0] = T_NONSEQ;
        tr[8] = T_NONSEQ; bu[8] = 3'd7; bu[9] = 3'd7; bu[10] = 3'd7;
        tr[11] = T_NONSEQ; bu[11] = 3'd2; bu[12] = 3'd2;
        tr[12] = T_SEQ;
        tr[13] = T_IDLE; bu[13] = 3'd0;
        tr[11] = T_NONSEQ;
        granted = 8'hFF; slvHREADYOUT = 8'hFF; HSEL = 1'b1; HMASTLOCK = 1'b0;
        for (int i = 0; i < 14; i++) begin
            HTRANS = tr[i]; HBURST = bu[i]; HADDR = 32'h3000_0000 + 32'(4 * i);
            rd = $urandom; srdata[3] = rd;
            #1;
            checks++;
            if (HREADYOUT !== 1'b1 || can_switch !== {8{exp_cnt == 0}}) begin
                failures++;
                $display("FAIL burst b%0d got rdy=%b cs=%h exp 1 %h",
                         i, HREADYOUT, can_switch, {8{exp_cnt == 0}});
            end
            checks++;
            if (slvHSEL !== ((tr[i] == T_IDLE) ? 8'h00 : 8'h08)
                || HRDATA !== (was_active ? rd : 32'h0)) begin
                failures++;
                $display("FAIL burst_route b%0d got sel=%h rd=%h exp_rd=%h",
                         i, slvHSEL, HRDATA, was_active ? rd : 32'h0);
            end
            if (tr[i] == T_NONSEQ) exp_cnt = exp_len(bu[i]);
            else if (tr[i] == T_SEQ && exp_cnt > 0) exp_cnt--;
            was_active = (tr[i] != T_IDLE);
            tick();
        end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_mid();
        drive_idle();
        HSEL = 1'b1; HADDR = 32'h2000_0010; HTRANS = T_NONSEQ; HWRITE = 1'b1;
        tick();
        checks++;
        if (HREADYOUT !== 1'b0 || slvHSEL !== 8'h04) begin
            failures++;
            $display("FAIL rst_wait_pre got rdy=%b sel=%h exp 0 04", HREADYOUT, slvHSEL);
        end
        HRESET = 1'b1; drive_idle();
        tick();
        checks++;
        if (HREADYOUT !== 1'b1 || slvHSEL !== 8'h00 || can_switch !== 8'hFF
            || HRESP !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait got rdy=%b sel=%h cs=%h resp=%b exp 1 00 ff 0",
                     HREADYOUT, slvHSEL, can_switch, HRESP);
        end
        HRESET = 1'b0;
        tick();
        granted = 8'hFF; HSEL = 1'b1; HBURST = 3'd5;
        for (int i = 0; i < 3; i++) begin
            HTRANS = (i == 0) ? T_NONSEQ : T_SEQ;
            HADDR  = 32'h4000_0000 + 32'(4 * i);
            tick();
        end
        checks++;
        if (can_switch !== 8'h00) begin
            failures++;
            $display("FAIL rst_burst_pre got cs=%h exp 00", can_switch);
        end
        HRESET = 1'b1; drive_idle();
        tick();
        checks++;
        if (can_switch !== 8'hFF || HREADYOUT !== 1'b1 || slvHSEL !== 8'h00) begin
            failures++;
            $display("FAIL rst_burst got cs=%h rdy=%b sel=%h exp ff 1 00",
                     can_switch, HREADYOUT, slvHSEL);
        end
        HRESET = 1'b0;
        exp_cnt = 0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            a = {4'($urandom_range(0, 15)), 28'($urandom) & 28'hFFF_FFFC};
            xfer(a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2), "rand");
        end
    endtask

    initial begin
        for (int s = 0; s < 7; s++) begin
            base[s] = 32'(s) << 28;
            mask[s] = 32'hF000_0000;
            srdata[s] = 32'h0;
        end
        // Slave 7 overlaps slaves 0..6 and only wins for the 0x7 region.
        base[7] = 32'h1000_0000; mask[7] = 32'h8000_0000; srdata[7] = 32'h0;
        HWDATA = 32'h0; HADDR = 32'h0; HSIZE = 3'd2; HPROT = 4'h3;
        drive_idle();
        HRESET = 1'b1;
        test_reset();
        test_single_write();
        test_stall();
        test_unmapped();
        test_lock();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
